// File: rtl/voting_pkg.sv
// Shared definitions for the voting session controller: FSM states and verdict codes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package voting_pkg;

   // Session phases: idle after reset, ballot collection, serial count, verdict held.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OPEN  = 2'd1,
      ST_TALLY = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // One-hot verdict codes as seen by the display driver.
   localparam logic [2:0] RES_NONE = 3'b000;
   localparam logic [2:0] RES_PASS = 3'b001;
   localparam logic [2:0] RES_TIE  = 3'b010;
   localparam logic [2:0] RES_FAIL = 3'b100;

endpackage

// File: rtl/vote_classifier.sv
// Turns final yes/cast counts into a one-hot verdict and a quorum flag.
// Latency: combinational; the caller registers the outputs.
// Backpressure: none; the output follows the inputs.
module vote_classifier
   import voting_pkg::*;
#(
   parameter int N_VOTERS = 4,
   parameter int QUORUM   = 1,
   parameter int MODE     = 0,
   parameter int CW       = $clog2(N_VOTERS + 1)
) (
   input  logic [CW-1:0] yes_count_i,
   input  logic [CW-1:0] cast_count_i,
   output logic [2:0]    result_o,
   output logic          no_quorum_o
);

   // One extra bit so that doubling the yes count can never wrap.
   localparam logic [CW:0] N_W = (CW+1)'(N_VOTERS);
   localparam logic [CW:0] Q_W = (CW+1)'(QUORUM);

   logic [CW:0] denom;
   logic [CW:0] twice_yes;
   logic [CW:0] cast_w;

   // Majority test against the configured denominator, quorum overrides everything.
   always_comb begin
      cast_w      = {1'b0, cast_count_i};
      twice_yes   = {yes_count_i, 1'b0};
      denom       = (MODE != 0) ? cast_w : N_W;
      no_quorum_o = (cast_w < Q_W);
      result_o    = RES_FAIL;
      if (!no_quorum_o) begin
         if (twice_yes > denom) begin
            result_o = RES_PASS;
         end else if (twice_yes == denom) begin
            result_o = RES_TIE;
         end else begin
            result_o = RES_FAIL;
         end
      end
   end

endmodule

// File: rtl/vote_session_ctrl.sv
// Runs one voting session at a time: collect ballots, tally serially, hold a registered verdict.
// Latency: OPEN exit at edge t gives result_valid after edge t+N_VOTERS+1.
// Backpressure: none; start is ignored while busy, close is ignored outside OPEN.
module vote_session_ctrl
   import voting_pkg::*;
#(
   parameter int N_VOTERS    = 4,
   parameter int QUORUM      = 1,
   parameter int TIMEOUT_CYC = 16,
   parameter int MODE        = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          close,
   input  logic [N_VOTERS-1:0]           vote_en,
   input  logic [N_VOTERS-1:0]           vote_yes,
   output logic                          busy,
   output logic [N_VOTERS-1:0]           voted,
   output logic [2:0]                    result,
   output logic                          result_valid,
   output logic                          no_quorum,
   output logic [$clog2(N_VOTERS+1)-1:0] yes_count,
   output logic [$clog2(N_VOTERS+1)-1:0] cast_count
);

   localparam int CW   = $clog2(N_VOTERS + 1);
   // Tally index runs 0..N_VOTERS; the final value is the verdict-latch cycle.
   localparam int IW   = $clog2(N_VOTERS + 1);
   localparam int TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int TMAX = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

   localparam logic [TW-1:0]       TMAX_W = TW'(TMAX);
   localparam logic [IW-1:0]       ILAST  = IW'(N_VOTERS);
   localparam logic [N_VOTERS-1:0] ONE_V  = {{(N_VOTERS-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [N_VOTERS-1:0] voted_q, voted_d;
   logic [N_VOTERS-1:0] ballot_q, ballot_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [CW-1:0]       yes_cnt_q, yes_cnt_d;
   logic [CW-1:0]       cast_cnt_q, cast_cnt_d;
   logic [2:0]          result_q, result_d;
   logic                nq_q, nq_d;

   logic [N_VOTERS-1:0] accept;
   logic [N_VOTERS-1:0] voted_nxt;
   logic [N_VOTERS-1:0] tally_sel;
   logic                cur_cast;
   logic                cur_yes;
   logic                timeout_hit;
   logic                open_exit;
   logic                tally_last;
   logic [2:0]          cls_result;
   logic                cls_nq;

   // First ballot per voter wins; the mask including this cycle decides a full ballot.
   assign accept      = vote_en & ~voted_q;
   assign voted_nxt   = voted_q | accept;
   assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TMAX_W);
   assign open_exit   = close || timeout_hit || (&voted_nxt);
   assign tally_last  = (idx_q == ILAST);

   // Index past the last voter selects nothing, so the latch cycle adds zero.
   assign tally_sel = ONE_V << idx_q;
   assign cur_cast  = |(voted_q & tally_sel);
   assign cur_yes   = |(voted_q & ballot_q & tally_sel);

   vote_classifier #(
      .N_VOTERS (N_VOTERS),
      .QUORUM   (QUORUM),
      .MODE     (MODE),
      .CW       (CW)
   ) u_classifier (
      .yes_count_i  (yes_cnt_q),
      .cast_count_i (cast_cnt_q),
      .result_o     (cls_result),
      .no_quorum_o  (cls_nq)
   );

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Session sequencing.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start)      state_d = ST_OPEN;
         ST_OPEN:  if (open_exit)  state_d = ST_TALLY;
         ST_TALLY: if (tally_last) state_d = ST_DONE;
         ST_DONE:  if (start)      state_d = ST_OPEN;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the current state.
   always_comb begin
      busy         = (state_q == ST_OPEN) || (state_q == ST_TALLY);
      result_valid = (state_q == ST_DONE);
   end

   assign voted      = voted_q;
   assign result     = result_q;
   assign no_quorum  = nq_q;
   assign yes_count  = yes_cnt_q;
   assign cast_count = cast_cnt_q;

   // Datapath registers: ballots, timer, tally counters and the latched verdict.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q    <= '0;
         voted_q    <= '0;
         ballot_q   <= '0;
         idx_q      <= '0;
         yes_cnt_q  <= '0;
         cast_cnt_q <= '0;
         result_q   <= RES_NONE;
         nq_q       <= 1'b0;
      end else begin
         timer_q    <= timer_d;
         voted_q    <= voted_d;
         ballot_q   <= ballot_d;
         idx_q      <= idx_d;
         yes_cnt_q  <= yes_cnt_d;
         cast_cnt_q <= cast_cnt_d;
         result_q   <= result_d;
         nq_q       <= nq_d;
      end
   end

   // Per-state datapath updates; everything holds unless the phase acts on it.
   always_comb begin
      timer_d    = timer_q;
      voted_d    = voted_q;
      ballot_d   = ballot_q;
      idx_d      = idx_q;
      yes_cnt_d  = yes_cnt_q;
      cast_cnt_d = cast_cnt_q;
      result_d   = result_q;
      nq_d       = nq_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               timer_d    = '0;
               voted_d    = '0;
               ballot_d   = '0;
               idx_d      = '0;
               yes_cnt_d  = '0;
               cast_cnt_d = '0;
               result_d   = RES_NONE;
               nq_d       = 1'b0;
            end
         end
         ST_OPEN: begin
            voted_d  = voted_nxt;
            ballot_d = (ballot_q & ~accept) | (vote_yes & accept);
            timer_d  = timer_q + TW'(1);
            idx_d    = '0;
         end
         ST_TALLY: begin
            if (tally_last) begin
               result_d = cls_result;
               nq_d     = cls_nq;
            end else begin
               cast_cnt_d = cast_cnt_q + {{(CW-1){1'b0}}, cur_cast};
               yes_cnt_d  = yes_cnt_q + {{(CW-1){1'b0}}, cur_yes};
               idx_d      = idx_q + IW'(1);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Scoreboard bench: three controller instances (MODE 0, MODE 1, QUORUM 3) share stimulus.
// Latency: verdict expected exactly N+1 edges after the modelled OPEN exit edge.
// Backpressure: none; sessions are issued only once the previous one is in DONE.
module tb_vote_session_ctrl;

   localparam int N  = 4;
   localparam int TO = 16;

   typedef struct {
      logic [2:0] res;
      logic       nq;
      int         yes;
      int         cast;
      logic [3:0] mask;
      int         due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       close = 1'b0;
   logic [3:0] vote_en = '0;
   logic [3:0] vote_yes = '0;

   logic       busy_w [3];
   logic [3:0] voted_w [3];
   logic [2:0] res_w [3];
   logic       rv_w [3];
   logic       nq_w [3];
   logic [2:0] yes_w [3];
   logic [2:0] cast_w [3];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb0[$];
   exp_t sb1[$];
   exp_t sb2[$];
   logic prv [3] = '{1'b0, 1'b0, 1'b0};

   logic [3:0] st_en[$];
   logic [3:0] st_yes[$];
   logic       st_cl[$];

   vote_session_ctrl #(.N_VOTERS(N), .QUORUM(1), .TIMEOUT_CYC(TO), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .close(close), .vote_en(vote_en), .vote_yes(vote_yes),
      .busy(busy_w[0]), .voted(voted_w[0]), .result(res_w[0]), .result_valid(rv_w[0]),
      .no_quorum(nq_w[0]), .yes_count(yes_w[0]), .cast_count(cast_w[0]));
   vote_session_ctrl #(.N_VOTERS(N), .QUORUM(1), .TIMEOUT_CYC(TO), .MODE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .close(close), .vote_en(vote_en), .vote_yes(vote_yes),
      .busy(busy_w[1]), .voted(voted_w[1]), .result(res_w[1]), .result_valid(rv_w[1]),
      .no_quorum(nq_w[1]), .yes_count(yes_w[1]), .cast_count(cast_w[1]));
   vote_session_ctrl #(.N_VOTERS(N), .QUORUM(3), .TIMEOUT_CYC(TO), .MODE(0)) dut2 (
      .clk(clk), .rst(rst), .start(start), .close(close), .vote_en(vote_en), .vote_yes(vote_yes),
      .busy(busy_w[2]), .voted(voted_w[2]), .result(res_w[2]), .result_valid(rv_w[2]),
      .no_quorum(nq_w[2]), .yes_count(yes_w[2]), .cast_count(cast_w[2]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Verdict rule from the ballot counts, independent of any hardware structure.
   function automatic exp_t verdict(input int yes, input int cast, input int quorum, input int mode,
                                    input logic [3:0] mask, input int due);
      exp_t e;
      int   d;
      d      = (mode != 0) ? cast : N;
      e.yes  = yes;
      e.cast = cast;
      e.mask = mask;
      e.due  = due;
      e.nq   = (cast < quorum);
      if (e.nq)               e.res = 3'b100;
      else if (2 * yes > d)   e.res = 3'b001;
      else if (2 * yes == d)  e.res = 3'b010;
      else                    e.res = 3'b100;
      return e;
   endfunction

   task automatic compare_done(input int d, input exp_t e);
      string t;
      t = $sformatf("dut%0d", d);
      chk({t, " result"},     32'(res_w[d]),   32'(e.res));
      chk({t, " no_quorum"},  32'(nq_w[d]),    32'(e.nq));
      chk({t, " yes_count"},  32'(yes_w[d]),   32'(e.yes));
      chk({t, " cast_count"}, 32'(cast_w[d]),  32'(e.cast));
      chk({t, " voted"},      32'(voted_w[d]), 32'(e.mask));
      chk({t, " latency"},    32'(cyc),        32'(e.due));
   endtask

   task automatic unexpected(input int d);
      checks++;
      errors++;
      $display("FAIL dut%0d verdict: got result_valid with no session pending, expected none", d);
   endtask

   // Monitor: every rising result_valid must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rv_w[0] && !prv[0]) begin
         if (sb0.size() == 0) unexpected(0);
         else compare_done(0, sb0.pop_front());
      end
      if (rv_w[1] && !prv[1]) begin
         if (sb1.size() == 0) unexpected(1);
         else compare_done(1, sb1.pop_front());
      end
      if (rv_w[2] && !prv[2]) begin
         if (sb2.size() == 0) unexpected(2);
         else compare_done(2, sb2.pop_front());
      end
      prv[0] = rv_w[0];
      prv[1] = rv_w[1];
      prv[2] = rv_w[2];
   end

   task automatic push_cyc(input logic [3:0] en, input logic [3:0] yy, input logic cl);
      st_en.push_back(en);
      st_yes.push_back(yy);
      st_cl.push_back(cl);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " busy0"},  32'(busy_w[0]),  0);
      chk({tag, " busy1"},  32'(busy_w[1]),  0);
      chk({tag, " busy2"},  32'(busy_w[2]),  0);
      chk({tag, " valid"},  32'(rv_w[0]),    0);
      chk({tag, " result"}, 32'(res_w[0]),   0);
      chk({tag, " nq"},     32'(nq_w[0]),    0);
      chk({tag, " voted"},  32'(voted_w[0]), 0);
      chk({tag, " yes"},    32'(yes_w[0]),   0);
      chk({tag, " cast"},   32'(cast_w[0]),  0);
   endtask

   // One session: ballots come from the stimulus queues (zeros once empty).
   task automatic run_session(input bit tally_poke, input bit rst_tally);
      int         mv[4];
      int         my[4];
      logic [3:0] en, yy, mask;
      logic       cl;
      int         ycnt, ccnt, e_edge;
      bit         all, ex;
      for (int i = 0; i < 4; i++) begin mv[i] = 0; my[i] = 0; end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 64; c++) begin
         en = (st_en.size() != 0) ? st_en.pop_front() : 4'd0;
         yy = (st_yes.size() != 0) ? st_yes.pop_front() : 4'd0;
         cl = (st_cl.size() != 0) ? st_cl.pop_front() : 1'b0;
         vote_en = en; vote_yes = yy; close = cl;
         @(posedge clk); #1;
         vote_en = '0; vote_yes = '0; close = 1'b0;
         all = 1'b1;
         mask = '0;
         for (int i = 0; i < 4; i++) begin
            if (en[i] && mv[i] == 0) begin mv[i] = 1; my[i] = int'(yy[i]); end
            if (mv[i] == 0) all = 1'b0;
            mask[i] = (mv[i] != 0);
         end
         ex = cl || (c == TO - 1) || all;
         chk("busy in session", 32'(busy_w[0]), 1);
         chk("live voted", 32'(voted_w[0]), 32'(mask));
         if (ex) break;
      end
      st_en.delete(); st_yes.delete(); st_cl.delete();
      e_edge = cyc;
      ycnt = 0; ccnt = 0;
      for (int i = 0; i < 4; i++) begin
         ccnt += mv[i];
         ycnt += mv[i] * my[i];
      end
      if (rst_tally) begin
         @(posedge clk); #1;
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         check_idle("rst mid tally");
      end else begin
         sb0.push_back(verdict(ycnt, ccnt, 1, 0, mask, e_edge + N + 1));
         sb1.push_back(verdict(ycnt, ccnt, 1, 1, mask, e_edge + N + 1));
         sb2.push_back(verdict(ycnt, ccnt, 3, 0, mask, e_edge + N + 1));
         if (tally_poke) begin start = 1'b1; close = 1'b1; end
         repeat (2) begin @(posedge clk); #1; end
         start = 1'b0; close = 1'b0;
         repeat (N) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      repeat (2) begin @(posedge clk); #1; end
      check_idle("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle("idle after reset");

      // Full ballot in one cycle: voters 0-2 YES, 3 NO -> auto close, PASS 3/4.
      push_cyc(4'b1111, 4'b0111, 1'b0);
      run_session(1'b0, 1'b0);

      // Two YES then close: TIE in MODE 0, PASS in MODE 1, no quorum at QUORUM 3.
      push_cyc(4'b0011, 4'b0011, 1'b0);
      push_cyc(4'b0000, 4'b0000, 1'b1);
      run_session(1'b0, 1'b0);

      // Repeat ballot from voter 2: first YES stands.
      push_cyc(4'b0100, 4'b0100, 1'b0);
      push_cyc(4'b0100, 4'b0000, 1'b0);
      push_cyc(4'b0000, 4'b0000, 1'b1);
      run_session(1'b0, 1'b0);

      // Two ballots then timeout on the 16th open cycle.
      push_cyc(4'b0011, 4'b0001, 1'b0);
      run_session(1'b0, 1'b0);

      // start/close held during TALLY must not disturb the count.
      push_cyc(4'b1010, 4'b1010, 1'b0);
      push_cyc(4'b0000, 4'b0000, 1'b1);
      run_session(1'b1, 1'b0);

      // Reset while tallying.
      push_cyc(4'b1111, 4'b1111, 1'b0);
      run_session(1'b0, 1'b1);

      // Sweep every full ballot, closed in the same cycle.
      for (int p = 0; p < 16; p++) begin
         push_cyc(4'b1111, 4'(p), 1'b1);
         run_session(1'b0, 1'b0);
      end

      // Random sessions.
      for (int s = 0; s < 25; s++) begin
         for (int c = 0; c < 16; c++) begin
            push_cyc(4'($urandom & $urandom), 4'($urandom), ($urandom_range(0, 9) == 0));
         end
         run_session(($urandom_range(0, 3) == 0), 1'b0);
      end

      repeat (N + 3) begin @(posedge clk); #1; end
      chk("pending dut0", 32'(sb0.size()), 0);
      chk("pending dut1", 32'(sb1.size()), 0);
      chk("pending dut2", 32'(sb2.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
